xy_seq_driver: RTL
==================

# xy_seq_driver

Hardware stimulus/response engine for the two-input, two-flop lab FSM. On `start` it steps the FSM's `x`/`y` inputs through a fixed six-vector sequence, holds each vector for a programmable number of cycles, and samples the FSM's `A`/`B` outputs after every vector. Each sample is folded into an 8-bit signature so a single compare replaces cycle-by-cycle checking. It sits beside the lab FSM: its `x`/`y` outputs drive the FSM inputs, and the FSM's `A`/`B` outputs return into this block.

## Interface
- `HOLD_CYCLES`, 2, cycles each vector is driven before sampling; legal range 1..255.
- `SIG_SEED`, 8'h00, signature value loaded on `start`.

- `clk`  in  1  rising-edge clock; the only clock.
- `clear`  in  1  reset; asynchronous, active-high.
- `start`  in  1  begin a run; sampled only in IDLE.
- `A`  in  1  FSM state bit A (response).
- `B`  in  1  FSM state bit B (response).
- `x`  out  1  FSM input x (registered).
- `y`  out  1  FSM input y (registered).
- `busy`  out  1  high in DRIVE and SAMPLE.
- `done`  out  1  one-cycle pulse when a run completes.
- `vec_idx`  out  3  index of the vector currently driven (0..5).
- `signature`  out  8  accumulated response signature.

## Operation
- Vector table, fixed, as {x,y}: idx0=00, idx1=01, idx2=10, idx3=11, idx4=10, idx5=01.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE
  - x=y=0, busy=0.
  - If `start`=1: go to DRIVE with vec_idx=0, hold counter=0, signature=SIG_SEED, and {x,y}=table[0] loaded on the same edge.
- DRIVE
  - {x,y}=table[vec_idx]; the 8-bit hold counter increments each cycle.
  - When counter==HOLD_CYCLES-1: go to SAMPLE and clear the counter.
- SAMPLE (exactly 1 cycle)
  - x/y keep their DRIVE value.
  - Update signature: signature <= {signature[6:0], signature[7]} ^ {6'b0, A, B}.
  - If vec_idx==5: go to DONE.
  - Else: vec_idx+1, load {x,y}=table[vec_idx+1], go to DRIVE.
- DONE (1 cycle)
  - done=1, x=y=0, busy=0; then go to IDLE.
- `signature` and the final `vec_idx` (5) hold after DONE until the next `start`.
- `start` is ignored in DRIVE, SAMPLE and DONE; it is not queued.
- `clear` asserted at any time, including mid-run, forces reset values immediately with no output glitch beyond the asynchronous transition. The aborted run produces no `done`.

## Timing
- Reset values: x=0, y=0, busy=0, done=0, vec_idx=0, signature=SIG_SEED, state=IDLE.
- Edge E0 samples `start`=1.
  - x/y for vector 0 are valid from E0.
  - busy rises after E0.
  - Each vector occupies HOLD_CYCLES+1 cycles: HOLD_CYCLES in DRIVE plus 1 in SAMPLE.
- A/B are sampled at the rising edge that ends the SAMPLE cycle. The FSM therefore sees each vector for at least HOLD_CYCLES edges before sampling.
- `done` is high during the cycle following edge E0 + 6*(HOLD_CYCLES+1). With HOLD_CYCLES=2, that is the cycle after E18, so `done` is asserted from E18 to E19.
- busy falls on the same edge that `done` rises.
- `signature` holds its final value from the edge entering DONE.

## Test plan
- Reset mid-run:
  - Stimulus: assert `clear` during vector 3 of a run.
  - Required response: x=y=0, busy=0, vec_idx=0, signature=SIG_SEED immediately; no `done` pulse.
  - After `clear` deasserts, `start` runs a full sequence normally.
- Sequence order, HOLD_CYCLES=2:
  - Stimulus: `start` pulse.
  - Required response: {x,y} = 00,01,10,11,10,01, each for 3 cycles.
  - vec_idx steps 0..5; `done` is a single-cycle pulse 18 cycles after E0.
- Zero response:
  - Stimulus: A=B=0 throughout, SIG_SEED=8'h00.
  - Required response: final signature = 8'h00.
- Constant response:
  - Stimulus: A=B=1 throughout, SIG_SEED=8'h00.
  - Required response: signature steps 03, 05, 09, 11, 21, final 8'h41.
- Start while busy / back-to-back:
  - Stimulus: hold `start`=1 continuously.
  - Required response: no restart mid-run; the next run begins at the edge after the DONE cycle, and signature reloads SIG_SEED at that edge.
- HOLD_CYCLES=1 boundary:
  - Stimulus: `start` pulse.
  - Required response: each vector lasts 2 cycles; `done` is high the cycle after E12.

Source files
------------

// File: rtl/xy_seq_driver.sv
// ---------------------------------------------------------------------------
// xy_seq_driver
//   Stimulus/response engine for the two-input, two-flop lab FSM. A start
//   pulse steps {x,y} through a fixed six-entry vector table. Each vector is
//   held for HOLD_CYCLES cycles and followed by one SAMPLE cycle. At the edge
//   that ends the SAMPLE cycle, the FSM response {A,B} is folded into an
//   8-bit rotate/XOR signature.
//
// Parameters
//   HOLD_CYCLES : cycles each vector is driven before it is sampled (1..255)
//   SIG_SEED    : signature value loaded by reset and by start
//
// Ports
//   clk        in   rising-edge clock
//   clear      in   asynchronous active-high reset
//   start      in   begin a run; only looked at in IDLE
//   A, B       in   FSM state bits (the response)
//   x, y       out  FSM inputs (registered)
//   busy       out  high while in DRIVE or SAMPLE
//   done       out  single-cycle pulse when a run completes
//   vec_idx    out  index of the vector being driven (0..5)
//   signature  out  accumulated response signature
// ---------------------------------------------------------------------------
module xy_seq_driver #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [7:0]  SIG_SEED    = 8'h00
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic       A,
  input  logic       B,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic [2:0] vec_idx,
  output logic [7:0] signature
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [2:0] LAST_VEC  = 3'd5;

  // Fixed stimulus table, returned as {x,y}.
  function automatic logic [1:0] vec_xy(input logic [2:0] idx);
    logic [1:0] v;
    case (idx)
      3'd0:    v = 2'b00;
      3'd1:    v = 2'b01;
      3'd2:    v = 2'b10;
      3'd3:    v = 2'b11;
      3'd4:    v = 2'b10;
      3'd5:    v = 2'b01;
      default: v = 2'b00;
    endcase
    return v;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [1:0] xy_q, xy_d;
  logic [7:0] sig_q, sig_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    xy_d    = xy_q;
    sig_d   = sig_q;

    case (state_q)
      S_IDLE: begin
        xy_d = 2'b00;
        if (start) begin
          state_d = S_DRIVE;
          cnt_d   = 8'd0;
          idx_d   = 3'd0;
          sig_d   = SIG_SEED;
          xy_d    = vec_xy(3'd0);
        end
      end
      S_DRIVE: begin
        xy_d = vec_xy(idx_q);
        if (cnt_q == HOLD_LAST) begin
          state_d = S_SAMPLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SAMPLE: begin
        // Rotate left by one, then fold in the response on the low two bits.
        sig_d = {sig_q[6:0], sig_q[7]} ^ {6'b0, A, B};
        if (idx_q == LAST_VEC) begin
          state_d = S_DONE;
          xy_d    = 2'b00;
        end else begin
          state_d = S_DRIVE;
          idx_d   = idx_q + 3'd1;
          xy_d    = vec_xy(idx_q + 3'd1);
        end
      end
      S_DONE: begin
        // Signature and vec_idx stay frozen until the next start.
        state_d = S_IDLE;
        xy_d    = 2'b00;
      end
      default: begin
        state_d = S_IDLE;
        xy_d    = 2'b00;
      end
    endcase

    // Status flags are registered versions of the state being entered,
    // so they change on the same edge as the state.
    busy_d = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      xy_q    <= 2'b00;
      sig_q   <= SIG_SEED;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      xy_q    <= xy_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x         = xy_q[1];
  assign y         = xy_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign vec_idx   = idx_q;
  assign signature = sig_q;

endmodule
